// File: rtl/wave_config_ctrl_if.sv
// ---------------------------------------------------------------------------
// wave_config_ctrl_if : frame/tick inputs and committed generator parameters
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface wave_config_ctrl_if;
   logic [55:0] receive_data;
   logic        data_ready;
   logic        period_tick;
   logic [15:0] full_width;
   logic [7:0]  detect_efficiency;
   logic [7:0]  deadtime_width;
   logic [7:0]  noise_choose;
   logic [15:0] total_number;
   logic        gen_enable;
   logic        burst_done;
   logic        cfg_error;
   logic [7:0]  err_count;
   logic        pending;

   modport master (
      output receive_data, data_ready, period_tick,
      input  full_width, detect_efficiency, deadtime_width, noise_choose,
      input  total_number, gen_enable, burst_done, cfg_error, err_count, pending
   );

   modport slave (
      input  receive_data, data_ready, period_tick,
      output full_width, detect_efficiency, deadtime_width, noise_choose,
      output total_number, gen_enable, burst_done, cfg_error, err_count, pending
   );
endinterface

`default_nettype wire

// File: rtl/wave_config_ctrl.sv
// ---------------------------------------------------------------------------
// wave_config_ctrl : frame decode/range check, shadow set, burst sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module wave_config_ctrl #(
   parameter int REPEAT    = 1,
   parameter int MIN_FULL  = 16,
   parameter int MAX_EFF   = 100,
   parameter int MAX_NOISE = 3
) (
   input  logic               clk,
   input  logic               rst,
   wave_config_ctrl_if.slave  bus
);

   localparam logic [15:0] c_RST_FW     = 16'd200;
   localparam logic [7:0]  c_RST_EFF    = 8'd50;
   localparam logic [7:0]  c_RST_DT     = 8'd8;
   localparam logic [7:0]  c_RST_NOISE  = 8'd3;
   localparam logic [15:0] c_RST_TN     = 16'd41;
   localparam logic [15:0] c_OFFSET     = 16'h0100;
   localparam logic [15:0] c_TN_MIN_RAW = 16'h0101;
   localparam logic [16:0] c_FW_MIN_RAW = 17'(32'h0100 + MIN_FULL);
   localparam logic [8:0]  c_MAX_EFF    = 9'(MAX_EFF);
   localparam logic [8:0]  c_MAX_NOISE  = 9'(MAX_NOISE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   logic [15:0] w_raw_fw;
   logic [15:0] w_raw_tn;
   logic [7:0]  w_eff;
   logic [7:0]  w_dt;
   logic [7:0]  w_noise;
   logic [15:0] w_fw;
   logic [15:0] w_tn;
   logic        w_legal;
   logic        w_accept;
   logic        w_reject;

   state_t      state_q;
   logic [15:0] count_q;
   logic [15:0] full_width_q;
   logic [7:0]  efficiency_q;
   logic [7:0]  deadtime_q;
   logic [7:0]  noise_q;
   logic [15:0] total_q;
   logic        gen_enable_q;
   logic        burst_done_q;

   logic [15:0] sh_fw_q;
   logic [7:0]  sh_eff_q;
   logic [7:0]  sh_dt_q;
   logic [7:0]  sh_noise_q;
   logic [15:0] sh_tn_q;
   logic        pending_q;
   logic        pending_d;
   logic        cfg_error_q;
   logic [7:0]  err_count_q;

   assign w_raw_fw = bus.receive_data[55:40];
   assign w_eff    = bus.receive_data[39:32];
   assign w_dt     = bus.receive_data[31:24];
   assign w_noise  = bus.receive_data[23:16];
   assign w_raw_tn = bus.receive_data[15:0];
   assign w_fw     = w_raw_fw - c_OFFSET;
   assign w_tn     = w_raw_tn - c_OFFSET;

   // The raw-width floor also rejects raw values below the offset, whose
   // wrapped decode would otherwise look huge and pass the dead-time test.
   assign w_legal  = ({1'b0, w_raw_fw} >= c_FW_MIN_RAW)
                   && (w_fw > {8'd0, w_dt})
                   && ({1'b0, w_eff} <= c_MAX_EFF)
                   && ({1'b0, w_noise} <= c_MAX_NOISE)
                   && (w_raw_tn >= c_TN_MIN_RAW);

   assign w_accept = bus.data_ready & w_legal;
   assign w_reject = bus.data_ready & ~w_legal;

   // A frame arriving on the committing edge wins, so it waits for the next boundary.
   always_comb begin
      pending_d = pending_q;
      if (w_accept) begin
         pending_d = 1'b1;
      end else if (state_q == S_LOAD) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_fw_q     <= c_RST_FW;
         sh_eff_q    <= c_RST_EFF;
         sh_dt_q     <= c_RST_DT;
         sh_noise_q  <= c_RST_NOISE;
         sh_tn_q     <= c_RST_TN;
         pending_q   <= 1'b0;
         cfg_error_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         pending_q   <= pending_d;
         cfg_error_q <= w_reject;
         if (w_accept) begin
            sh_fw_q    <= w_fw;
            sh_eff_q   <= w_eff;
            sh_dt_q    <= w_dt;
            sh_noise_q <= w_noise;
            sh_tn_q    <= w_tn;
         end
         if (w_reject && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         count_q      <= 16'd0;
         full_width_q <= c_RST_FW;
         efficiency_q <= c_RST_EFF;
         deadtime_q   <= c_RST_DT;
         noise_q      <= c_RST_NOISE;
         total_q      <= c_RST_TN;
         gen_enable_q <= 1'b0;
         burst_done_q <= 1'b0;
      end else begin
         burst_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               gen_enable_q <= 1'b0;
               if (pending_q) begin
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (pending_q) begin
                  full_width_q <= sh_fw_q;
                  efficiency_q <= sh_eff_q;
                  deadtime_q   <= sh_dt_q;
                  noise_q      <= sh_noise_q;
                  total_q      <= sh_tn_q;
               end
               count_q      <= 16'd0;
               gen_enable_q <= 1'b1;
               state_q      <= S_RUN;
            end
            S_RUN: begin
               if (bus.period_tick) begin
                  if (count_q == (total_q - 16'd1)) begin
                     gen_enable_q <= 1'b0;
                     burst_done_q <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     count_q <= count_q + 16'd1;
                  end
               end
            end
            S_DONE: begin
               gen_enable_q <= 1'b0;
               if (pending_q || (REPEAT != 0)) begin
                  state_q <= S_LOAD;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               gen_enable_q <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.full_width        = full_width_q;
   assign bus.detect_efficiency = efficiency_q;
   assign bus.deadtime_width    = deadtime_q;
   assign bus.noise_choose      = noise_q;
   assign bus.total_number      = total_q;
   assign bus.gen_enable        = gen_enable_q;
   assign bus.burst_done        = burst_done_q;
   assign bus.cfg_error         = cfg_error_q;
   assign bus.err_count         = err_count_q;
   assign bus.pending           = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_config_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_config_ctrl : scoreboard bench for wave_config_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_wave_config_ctrl;

   typedef struct packed {
      logic [15:0] fw;
      logic [7:0]  eff;
      logic [7:0]  dt;
      logic [7:0]  noise;
      logic [15:0] tn;
   } cfg_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   bit   ge_prev  = 1'b0;
   cfg_t mon_e;
   int   mon_cnt;
   bit   mon_pend;

   cfg_t q_commit[$];
   cfg_t q_done[$];
   int   q_err_cnt[$];
   bit   q_err_pend[$];

   wave_config_ctrl_if m ();
   wave_config_ctrl_if m0 ();

   always #5 clk = ~clk;

   wave_config_ctrl #(.REPEAT(1), .MIN_FULL(16), .MAX_EFF(100), .MAX_NOISE(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (m.slave)
   );

   // Second instance without auto-repeat, fed the same stimulus.
   wave_config_ctrl #(.REPEAT(0), .MIN_FULL(16), .MAX_EFF(100), .MAX_NOISE(3)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (m0.slave)
   );

   assign m0.receive_data = m.receive_data;
   assign m0.data_ready   = m.data_ready;
   assign m0.period_tick  = m.period_tick;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_cfg(input string name, input cfg_t e);
      chk({name, ".full_width"},  32'(m.full_width),        32'(e.fw));
      chk({name, ".efficiency"},  32'(m.detect_efficiency), 32'(e.eff));
      chk({name, ".deadtime"},    32'(m.deadtime_width),    32'(e.dt));
      chk({name, ".noise"},       32'(m.noise_choose),      32'(e.noise));
      chk({name, ".total"},       32'(m.total_number),      32'(e.tn));
   endtask

   function automatic cfg_t mkc(input logic [15:0] fw, input logic [7:0] eff,
                                input logic [7:0] dt, input logic [7:0] noise,
                                input logic [15:0] tn);
      cfg_t c;
      c.fw = fw; c.eff = eff; c.dt = dt; c.noise = noise; c.tn = tn;
      return c;
   endfunction

   function automatic logic [55:0] frm(input logic [15:0] fw_raw, input logic [7:0] eff,
                                       input logic [7:0] dt, input logic [7:0] noise,
                                       input logic [15:0] tn_raw);
      return {fw_raw, eff, dt, noise, tn_raw};
   endfunction

   // Monitor: pops expectations whenever the DUT presents an event.
   always @(negedge clk) begin
      if (rst == 1'b0) begin
         ge_prev = 1'b0;
      end else begin
         if (m.gen_enable && !ge_prev) begin
            if (q_commit.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_commit: actual=commit required=none");
            end else begin
               mon_e = q_commit.pop_front();
               cmp_cfg("commit", mon_e);
            end
         end
         ge_prev = m.gen_enable;
         if (m.burst_done) begin
            if (q_done.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_burst_done: actual=pulse required=none");
            end else begin
               mon_e = q_done.pop_front();
               cmp_cfg("burst_done", mon_e);
            end
         end
         if (m.cfg_error) begin
            if (q_err_cnt.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_cfg_error: actual=pulse required=none");
            end else begin
               mon_cnt  = q_err_cnt.pop_front();
               mon_pend = q_err_pend.pop_front();
               chk("cfg_error.err_count", 32'(m.err_count), 32'(mon_cnt));
               chk("cfg_error.pending",   32'(m.pending),   32'(mon_pend));
            end
         end
      end
   end

   task automatic send_frame(input logic [55:0] f);
      @(posedge clk); #1;
      m.receive_data = f;
      m.data_ready   = 1'b1;
      @(posedge clk); #1;
      m.data_ready   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      m.period_tick = 1'b1;
      @(posedge clk); #1;
      m.period_tick = 1'b0;
   endtask

   task automatic frame_tick(input logic [55:0] f);
      @(posedge clk); #1;
      m.receive_data = f;
      m.data_ready   = 1'b1;
      m.period_tick  = 1'b1;
      @(posedge clk); #1;
      m.data_ready   = 1'b0;
      m.period_tick  = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int maxc);
      int n = 0;
      while ((q_commit.size() + q_done.size() + q_err_cnt.size()) != 0 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      chk({name, ".outstanding"}, 32'(q_commit.size() + q_done.size() + q_err_cnt.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [55:0] bad_frames [6];
      int bad;

      m.receive_data = '0;
      m.data_ready   = 1'b0;
      m.period_tick  = 1'b0;

      bad_frames[0] = frm(16'h01C8, 8'h65, 8'h08, 8'h02, 16'h0104); // efficiency 101
      bad_frames[1] = frm(16'h00FF, 8'h32, 8'h08, 8'h02, 16'h0104); // raw width below offset
      bad_frames[2] = frm(16'h0108, 8'h32, 8'h08, 8'h02, 16'h0104); // fw 8, dead time 8
      bad_frames[3] = frm(16'h0120, 8'h32, 8'h20, 8'h02, 16'h0104); // fw 32 == dead time 32
      bad_frames[4] = frm(16'h01C8, 8'h32, 8'h08, 8'h04, 16'h0104); // noise 4
      bad_frames[5] = frm(16'h01C8, 8'h32, 8'h08, 8'h02, 16'h0100); // total 0

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.full_width", 32'(m.full_width),        32'd200);
      chk("rst.efficiency", 32'(m.detect_efficiency), 32'd50);
      chk("rst.deadtime",   32'(m.deadtime_width),    32'd8);
      chk("rst.noise",      32'(m.noise_choose),      32'd3);
      chk("rst.total",      32'(m.total_number),      32'd41);
      chk("rst.gen_enable", 32'(m.gen_enable),        32'd0);
      chk("rst.burst_done", 32'(m.burst_done),        32'd0);
      chk("rst.cfg_error",  32'(m.cfg_error),         32'd0);
      chk("rst.err_count",  32'(m.err_count),         32'd0);
      chk("rst.pending",    32'(m.pending),           32'd0);
      #2 rst = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (m.gen_enable !== 1'b0 || m0.gen_enable !== 1'b0) bad++;
      end
      chk("idle_1000.gen_enable_cycles", 32'(bad), 32'd0);

      // First legal frame in IDLE: E0 pending, E1 LOAD, E2 commit
      q_commit.push_back(mkc(16'd200, 8'd50, 8'd8, 8'd2, 16'd4));
      send_frame(frm(16'h01C8, 8'h32, 8'h08, 8'h02, 16'h0104));
      @(negedge clk);
      chk("e0.pending",    32'(m.pending),      32'd1);
      chk("e0.gen_enable", 32'(m.gen_enable),   32'd0);
      @(negedge clk);
      chk("e1.gen_enable", 32'(m.gen_enable),   32'd0);
      chk("e1.noise",      32'(m.noise_choose), 32'd3);
      @(negedge clk);
      chk("e2.gen_enable", 32'(m.gen_enable),   32'd1);
      chk("e2.pending",    32'(m.pending),      32'd0);
      chk("e2.total",      32'(m.total_number), 32'd4);

      // Four-period burst
      q_done.push_back(mkc(16'd200, 8'd50, 8'd8, 8'd2, 16'd4));
      q_commit.push_back(mkc(16'd200, 8'd50, 8'd8, 8'd2, 16'd4));
      repeat (3) tick();
      chk("tick3.gen_enable", 32'(m.gen_enable), 32'd1);
      tick();
      @(negedge clk);
      chk("done.gen_enable", 32'(m.gen_enable), 32'd0);
      chk("done.burst_done", 32'(m.burst_done), 32'd1);
      @(negedge clk);
      chk("load.gen_enable", 32'(m.gen_enable), 32'd0);
      chk("load.burst_done", 32'(m.burst_done), 32'd0);
      @(negedge clk);
      chk("rerun.gen_enable",          32'(m.gen_enable),  32'd1);
      chk("norepeat.gen_enable_idle",  32'(m0.gen_enable), 32'd0);
      wait_drain("burst4", 50);

      // Illegal frames
      for (int i = 0; i < 6; i++) begin
         q_err_cnt.push_back(i + 1);
         q_err_pend.push_back(1'b0);
         send_frame(bad_frames[i]);
      end
      wait_drain("illegal", 20);
      chk("illegal.pending",   32'(m.pending),      32'd0);
      chk("illegal.noise",     32'(m.noise_choose), 32'd2);
      chk("illegal.err_count", 32'(m.err_count),    32'd6);

      // Frame shadowed mid-burst, committed after burst_done
      q_done.push_back(mkc(16'd200, 8'd50, 8'd8, 8'd2, 16'd4));
      q_commit.push_back(mkc(16'h00F4, 8'h40, 8'h10, 8'h01, 16'd41));
      send_frame(frm(16'h01F4, 8'h40, 8'h10, 8'h01, 16'h0129));
      repeat (4) tick();
      wait_drain("burst_to_41", 50);

      // Boundary-legal frame held through a 41-period burst
      q_done.push_back(mkc(16'h00F4, 8'h40, 8'h10, 8'h01, 16'd41));
      q_commit.push_back(mkc(16'd16, 8'd100, 8'd15, 8'd3, 16'd1));
      send_frame(frm(16'h0110, 8'd100, 8'd15, 8'd3, 16'h0101));
      @(negedge clk);
      chk("mid41.pending",    32'(m.pending),    32'd1);
      chk("mid41.full_width", 32'(m.full_width), 32'h00F4);
      repeat (40) tick();
      @(negedge clk);
      chk("tick40.gen_enable", 32'(m.gen_enable),   32'd1);
      chk("tick40.full_width", 32'(m.full_width),   32'h00F4);
      chk("tick40.total",      32'(m.total_number), 32'd41);
      tick();
      wait_drain("burst41", 50);

      // Frame on the same edge as the final tick
      q_done.push_back(mkc(16'd16, 8'd100, 8'd15, 8'd3, 16'd1));
      q_commit.push_back(mkc(16'd100, 8'h20, 8'h05, 8'h00, 16'd3));
      frame_tick(frm(16'h0164, 8'h20, 8'h05, 8'h00, 16'h0103));
      @(negedge clk);
      chk("same_edge.burst_done", 32'(m.burst_done), 32'd1);
      chk("same_edge.pending",    32'(m.pending),    32'd1);
      wait_drain("same_edge", 50);
      chk("same_edge.pending_after", 32'(m.pending), 32'd0);

      // Frame sampled on the LOAD->RUN edge waits a full burst
      q_done.push_back(mkc(16'd100, 8'h20, 8'h05, 8'h00, 16'd3));
      q_commit.push_back(mkc(16'd100, 8'h20, 8'h05, 8'h00, 16'd3));
      repeat (3) tick();
      send_frame(frm(16'h0150, 8'h10, 8'h04, 8'h01, 16'h0102));
      @(negedge clk);
      chk("load_edge.pending",    32'(m.pending),    32'd1);
      chk("load_edge.gen_enable", 32'(m.gen_enable), 32'd1);
      chk("load_edge.full_width", 32'(m.full_width), 32'd100);
      wait_drain("load_edge_a", 50);
      q_done.push_back(mkc(16'd100, 8'h20, 8'h05, 8'h00, 16'd3));
      q_commit.push_back(mkc(16'h0050, 8'h10, 8'h04, 8'h01, 16'd2));
      repeat (3) tick();
      wait_drain("load_edge_b", 50);

      // Saturation with a frame pending, then asynchronous reset in RUN
      send_frame(frm(16'h01C8, 8'h32, 8'h08, 8'h02, 16'h0104));
      for (int i = 0; i < 300; i++) begin
         q_err_cnt.push_back((7 + i > 255) ? 255 : 7 + i);
         q_err_pend.push_back(1'b1);
         send_frame(frm(16'h01C8, 8'hFF, 8'h08, 8'h02, 16'h0104));
      end
      wait_drain("saturate", 20);
      chk("sat.err_count",  32'(m.err_count),  32'd255);
      chk("sat.pending",    32'(m.pending),    32'd1);
      chk("sat.gen_enable", 32'(m.gen_enable), 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst.gen_enable", 32'(m.gen_enable),        32'd0);
      chk("arst.err_count",  32'(m.err_count),         32'd0);
      chk("arst.full_width", 32'(m.full_width),        32'd200);
      chk("arst.efficiency", 32'(m.detect_efficiency), 32'd50);
      chk("arst.deadtime",   32'(m.deadtime_width),    32'd8);
      chk("arst.noise",      32'(m.noise_choose),      32'd3);
      chk("arst.total",      32'(m.total_number),      32'd41);
      chk("arst.pending",    32'(m.pending),           32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (m.gen_enable !== 1'b0) bad++;
      end
      chk("post_rst.gen_enable_cycles", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wave_config_ctrl.md
# wave_config_ctrl

Sits between the UART frame receiver and the dead-time/photon waveform generator, and sequences that generator's bursts. It decodes and range-checks each 56-bit configuration frame, then holds an accepted frame in a shadow set. It commits the shadow set to the generator only on a burst boundary, so the generator never sees a half-updated parameter set. It gates the generator on for exactly `total_number` photon periods per burst, with optional automatic repeat.

## Interface
Parameters:
- `REPEAT`, 1, 1 restarts a burst automatically after each burst completes; 0 returns to idle.
- `MIN_FULL`, 16, minimum legal decoded full width in clocks.
- `MAX_EFF`, 100, maximum legal detect efficiency in percent.
- `MAX_NOISE`, 3, maximum legal noise_choose code.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-low reset.
- `receive_data`  in  56  frame from the UART: [55:40] full width (+0x0100 offset), [39:32] efficiency, [31:24] dead time, [23:16] noise select, [15:0] total number (+0x0100 offset).
- `data_ready`  in  1  one-cycle strobe; `receive_data` is valid while it is high.
- `period_tick`  in  1  one-cycle pulse from the generator at the end of each photon period.
- `full_width`  out  16  committed full width.
- `detect_efficiency`  out  8  committed efficiency.
- `deadtime_width`  out  8  committed dead time.
- `noise_choose`  out  8  committed noise select.
- `total_number`  out  16  committed periods per burst.
- `gen_enable`  out  1  generator run gate.
- `burst_done`  out  1  one-cycle pulse at the end of each burst.
- `cfg_error`  out  1  one-cycle pulse when a frame is rejected.
- `err_count`  out  8  count of rejected frames; saturates at 255.
- `pending`  out  1  a valid shadow set is waiting to be committed.

## Operation
- Decode is combinational on `receive_data`:
  - fw = [55:40] − 0x0100
  - tn = [15:0] − 0x0100
  - both subtractions are 16-bit.
- A frame is legal when all of the following hold:
  - raw [55:40] ≥ 0x0100 + MIN_FULL
  - fw > dead time
  - efficiency ≤ MAX_EFF
  - noise ≤ MAX_NOISE
  - raw [15:0] ≥ 0x0101, so tn ≥ 1
- A legal frame sampled on `data_ready` loads the shadow set and sets `pending`. A newer legal frame overwrites the shadow set (last frame wins).
- An illegal frame raises `cfg_error`, increments `err_count` (saturating), and leaves the shadow set and `pending` untouched.
- FSM states:
  - IDLE: `gen_enable`=0. Goes to LOAD when `pending`=1.
  - LOAD: one cycle. If `pending`=1, copies the shadow set to the outputs and clears `pending`; otherwise keeps the current outputs. Clears the period counter. Goes to RUN.
  - RUN: `gen_enable`=1. Increments the 16-bit period counter on each `period_tick`. On a `period_tick` with counter == `total_number`−1, goes to DONE.
  - DONE: one cycle, `gen_enable`=0, `burst_done`=1. Goes to LOAD if `pending` or REPEAT=1; otherwise goes to IDLE.
- Committed outputs change only on the LOAD→RUN edge. In RUN they are frozen regardless of incoming frames.
- `period_tick` is ignored outside RUN.

## Timing
- Reset values:
  - `full_width`=200, `detect_efficiency`=50, `deadtime_width`=8, `noise_choose`=3, `total_number`=41
  - `gen_enable`=0, `burst_done`=0, `cfg_error`=0, `err_count`=0, `pending`=0
  - shadow set = reset values, FSM state = IDLE
- Reset asserted mid-burst forces all reset values immediately and asynchronously; any pending frame is lost.
- Legal frame sampled at edge E0 while in IDLE:
  - E0: `pending`=1.
  - E1: state becomes LOAD.
  - E2: outputs are updated, `pending`=0, `gen_enable`=1.
- `cfg_error` is high for exactly the cycle after the edge that sampled the illegal frame.
- Burst length: `gen_enable` stays high until the edge that samples the `total_number`-th `period_tick`. It is then low for the DONE cycle and the LOAD cycle, and rises again on the LOAD→RUN edge (REPEAT=1).
- `data_ready` and the final `period_tick` on the same edge: the burst ends and the shadow set is loaded on that edge. DONE then goes to LOAD and commits the new frame.
- `data_ready` during DONE or LOAD: the frame is shadowed. If LOAD has already copied, the frame waits for the next burst boundary.

## Test plan
- Reset only, REPEAT=0: all outputs at reset values; `gen_enable` stays 0 for 1000 cycles.
- Legal frame {0x01C8, 0x32, 0x08, 0x02, 0x0104} in IDLE:
  - `full_width`=0xC8, `noise_choose`=2, `total_number`=4, all updated at E2.
  - `gen_enable` drops after the 4th `period_tick`, then `burst_done` pulses once.
- Illegal frames, each leaving outputs and `pending` unchanged:
  - efficiency 0x65 → `cfg_error` pulse, `err_count`=1.
  - raw full width 0x00FF → `err_count`=2.
  - fw=8 with dead time 8 → `err_count`=3.
- Frame received mid-burst with REPEAT=1, `total_number`=41:
  - outputs stay frozen through all 41 ticks.
  - the new values appear on the LOAD→RUN edge after `burst_done`.
- `data_ready` on the same edge as the final `period_tick`: `burst_done`=1 on the next cycle, then the new parameters are committed in the following LOAD.
- 300 illegal frames: `err_count` saturates at 255. Then assert reset during RUN: `gen_enable`=0, `err_count`=0, parameters return to defaults at once.
